seq_alu_param: RTL
==================

// Module: seq_alu_param
// PURPOSE
//   Parametrised, width-generic successor of the team's start/done ALU.
//   - Operands and opcode latched on start, so the source may change them freely afterwards.
//   - MUL uses an iterative shift-add multiplier (one partial product per cycle),
//     not a combinational array.
//   - Adds SUB, OR, a busy flag and an error flag.
//   - Sits behind a simple controller/testbench driver issuing one operation at a time.
// PARAMETERS
//   WIDTH     8     operand width in bits (>=2); result is 2*WIDTH bits
//   CNT_W     $clog2(WIDTH)+1   multiply iteration counter width (derived, do not override)
// PORTS
//   clk       in   1          rising-edge clock
//   reset_n   in   1          asynchronous active-low reset
//   start     in   1          request; sampled only while busy==0
//   A         in   WIDTH      operand A (unsigned)
//   B         in   WIDTH      operand B (unsigned)
//   op        in   3          opcode, see BEHAVIOUR
//   result    out  2*WIDTH    registered result, held until next completion
//   done      out  1          one-cycle completion pulse
//   busy      out  1          high while an operation is in flight
//   err       out  1          one-cycle pulse with done for reserved opcode
// BEHAVIOUR
//   Reset: state=IDLE, result=0, done=0, busy=0, err=0, internal regs=0. Reset mid-operation
//     aborts immediately; no done is produced for the aborted op.
//   All outputs are registered. busy = (state != IDLE).
//   States: IDLE -> CALC (op!=100) | MULT (op==100); CALC -> IDLE; MULT -> MULT x WIDTH -> RES -> IDLE.
//   IDLE: on edge N with start=1, latch A,B,op into a_q,b_q,op_q; acc=0, cnt=0.
//   CALC: at edge N+1, result <= f(a_q,b_q,op_q); done<=1 (except NOP); state->IDLE.
//   MULT: each edge, if b_q[cnt] then acc += a_q << cnt; cnt++; after WIDTH iterations
//     (edges N+1..N+WIDTH) go to RES.
//   RES: at edge N+WIDTH+1, result <= acc, done<=1; state->IDLE.
//   Latency (start-sample edge to done-high edge): 1 cycle logic ops, WIDTH+1 cycles MUL.
//   Opcodes (all unsigned, zero-extended to 2*WIDTH):
//     000 NOP  result<=0, done NOT asserted, err=0
//     001 ADD  {carry, A+B}, WIDTH+1 bits
//     010 AND  A&B
//     011 XOR  A^B
//     100 MUL  A*B, full 2*WIDTH bits
//     101 SUB  low WIDTH bits = A-B mod 2^WIDTH, bit WIDTH = borrow (A<B)
//     110 OR   A|B
//     111 reserved: result<=0, done=1, err=1
//   start while busy=1: ignored, no effect on in-flight op or latched operands.
//   Back-to-back: done cycle has state IDLE, so start in the same cycle is accepted (edge N+1
//     after done-edge) with zero bubble.
//   done and err are single-cycle pulses; result stays stable until overwritten by the next
//     completing op (NOP overwrites with 0).
// TESTING (WIDTH=8 unless stated)
//   1. ADD A=FF B=01 start 1 cycle -> done one cycle after start-edge, result=0x0100, err=0.
//   2. MUL A=FF B=FF -> busy high 9 cycles, done at edge N+9, result=0xFE01; change A/B to 00
//      at N+1 -> result unchanged.
//   3. SUB A=05 B=07 -> result=0x01FE; SUB A=07 B=05 -> 0x0002.
//   4. start held high during MUL A=03 B=04 with op switching to ADD -> single done,
//      result=0x000C; next op accepted on the done cycle.
//   5. reset_n low at MULT cycle 4 -> all outputs 0 same cycle, no done after release;
//      new ADD 01+01 -> 0x0002.
//   6. op=000 -> no done, busy pulse 1 cycle, result=0; op=111 -> done=err=1, result=0;
//      repeat test 2 at WIDTH=16 with FFFF*FFFF -> 0xFFFE0001 at N+17.

Source files
------------

// File: rtl/seq_alu_param.sv
// seq_alu_param: sequential ALU with a start/done handshake.
//   Logic ops (ADD/AND/XOR/SUB/OR) finish one cycle after start is sampled.
//   MUL is an iterative shift-add multiplier that adds one partial product
//   per cycle and finishes WIDTH+1 cycles after start is sampled.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    request, sampled only while idle
//   A, B     unsigned operands, latched when start is accepted
//   op       opcode (000 NOP, 001 ADD, 010 AND, 011 XOR, 100 MUL,
//            101 SUB, 110 OR, 111 reserved)
//   result   2*WIDTH-bit registered result, held until the next completion
//   done     one-cycle completion pulse (not raised for NOP)
//   busy     high while an operation is in flight
//   err      one-cycle pulse, raised together with done for the reserved opcode
module seq_alu_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [2:0]         op,
    output logic [2*WIDTH-1:0] result,
    output logic               done,
    output logic               busy,
    output logic               err
);

    localparam int RW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, MULT, RES} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [RW-1:0]    acc;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   sum, diff;
    logic [RW-1:0]    calc_res;
    logic [RW-1:0]    pp;
    logic [WIDTH-1:0] b_sh;

    // One extra bit gives the carry for ADD and the borrow for SUB: with
    // both operands zero-extended, bit WIDTH of the difference is set
    // exactly when A < B.
    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        calc_res = '0;
        case (op_q)
            3'b001:  calc_res = RW'(sum);
            3'b010:  calc_res = RW'(a_q & b_q);
            3'b011:  calc_res = RW'(a_q ^ b_q);
            3'b101:  calc_res = RW'(diff);
            3'b110:  calc_res = RW'(a_q | b_q);
            default: calc_res = '0;  // NOP and reserved both yield zero
        endcase
    end

    // Partial product for the current iteration. Shifting b_q down
    // selects multiplier bit cnt without indexing by a counter that is
    // wider than the bit select needs.
    assign pp   = RW'(a_q) << cnt;
    assign b_sh = b_q >> cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        op_q  <= op;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= (op == 3'b100) ? MULT : CALC;
                    end
                end
                CALC: begin
                    result <= calc_res;
                    done   <= (op_q != 3'b000);
                    err    <= (op_q == 3'b111);
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                MULT: begin
                    if (b_sh[0]) acc <= acc + pp;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state <= RES;
                end
                RES: begin
                    result <= acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
